// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: command inputs from the host
// and count/state outputs back to it.
interface countdown_timer_if #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
);
  logic                   start_i;
  logic                   stop_i;
  logic                   load_i;
  logic [WIDTH-1:0]       cnt_i;
  logic                   reload_en_i;
  logic [PRESC_WIDTH-1:0] presc_i;
  logic                   clr_i;
  logic [WIDTH-1:0]       cnt_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   underflow_o;

  modport master (
    output start_i, stop_i, load_i, cnt_i, reload_en_i, presc_i, clr_i,
    input  cnt_o, busy_o, done_o, underflow_o
  );

  modport slave (
    input  start_i, stop_i, load_i, cnt_i, reload_en_i, presc_i, clr_i,
    output cnt_o, busy_o, done_o, underflow_o
  );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled down-counter with one-shot/auto-reload expiry, IDLE/RUN/DONE control
// and a registered one-cycle underflow pulse.
module countdown_timer #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   tmr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       reload_q, reload_d;
  logic [PRESC_WIDTH-1:0] p_q, p_d;
  logic                   underflow_q, underflow_d;
  logic                   tick_s;

  // presc_i is compared live so lowering it mid-run ticks at once instead of wrapping
  assign tick_s = (state_q == RUN) && (p_q >= tmr.presc_i);

  // Next-state logic with priority stop > load > start > clr
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reload_d    = reload_q;
    p_d         = p_q;
    underflow_d = 1'b0;
    case (state_q)
      RUN: begin
        if (tmr.stop_i) begin
          state_d = IDLE;
          p_d     = PRESC_WIDTH'(0);
        end else begin
          if (tmr.load_i) begin
            reload_d = tmr.cnt_i;
          end else begin
            reload_d = reload_q;
          end
          if (tick_s) begin
            p_d = PRESC_WIDTH'(0);
            if (cnt_q != WIDTH'(0)) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              underflow_d = 1'b1;
              if (tmr.reload_en_i) begin
                cnt_d = reload_q;
              end else begin
                state_d = DONE;
              end
            end
          end else begin
            p_d = p_q + PRESC_WIDTH'(1);
          end
        end
      end
      IDLE, DONE: begin
        if (tmr.stop_i) begin
          state_d = IDLE;
        end else begin
          if (tmr.load_i) begin
            reload_d = tmr.cnt_i;
            cnt_d    = tmr.cnt_i;
          end else begin
            reload_d = reload_q;
          end
          if (tmr.start_i) begin
            state_d = RUN;
            p_d     = PRESC_WIDTH'(0);
          end else if (tmr.clr_i && !tmr.load_i) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= WIDTH'(0);
      reload_q    <= WIDTH'(0);
      p_q         <= PRESC_WIDTH'(0);
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reload_q    <= reload_d;
      p_q         <= p_d;
      underflow_q <= underflow_d;
    end
  end

  assign tmr.cnt_o       = cnt_q;
  assign tmr.busy_o      = (state_q == RUN);
  assign tmr.done_o      = (state_q == DONE);
  assign tmr.underflow_o = underflow_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expectations are queued with a due cycle
// when stimulus is driven and compared on the falling edge of that cycle.
module tb_countdown_timer;
  localparam int W  = 8;
  localparam int PW = 4;

  typedef struct {
    int           due;
    string        tag;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    logic         uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W), .PRESC_WIDTH(PW)) bus ();

  countdown_timer #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus)
  );

  task automatic check_due();
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].due == cyc) begin
        checks++;
        assert ({bus.cnt_o, bus.busy_o, bus.done_o, bus.underflow_o} ===
                {sb[i].cnt, sb[i].busy, sb[i].done, sb[i].uf})
        else begin
          fails++;
          $error("FAIL %s: observed cnt=%0d busy=%b done=%b uf=%b, expected cnt=%0d busy=%b done=%b uf=%b",
                 sb[i].tag, bus.cnt_o, bus.busy_o, bus.done_o, bus.underflow_o,
                 sb[i].cnt, sb[i].busy, sb[i].done, sb[i].uf);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // One clock: count the rising edge, then check whatever is due on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_due();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_at(input int d, input string tag, input int c,
                           input logic b, input logic dn, input logic u);
    exp_t e;
    e.due  = cyc + d;
    e.tag  = tag;
    e.cnt  = W'(c);
    e.busy = b;
    e.done = dn;
    e.uf   = u;
    sb.push_back(e);
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.load_i      = 1'b0;
    bus.cnt_i       = '0;
    bus.reload_en_i = 1'b0;
    bus.presc_i     = '0;
    bus.clr_i       = 1'b0;
    expect_at(1, "reset", 0, 1'b0, 1'b0, 1'b0);
    tick();

    // one-shot count 3, prescaler 0
    rst = 1'b0; bus.load_i = 1'b1; bus.cnt_i = 8'd3;
    expect_at(1, "load_idle", 3, 1'b0, 1'b0, 1'b0);
    tick();
    bus.load_i = 1'b0; bus.start_i = 1'b1;
    expect_at(1, "os_start",  3, 1'b1, 1'b0, 1'b0);
    expect_at(2, "os_dec2",   2, 1'b1, 1'b0, 1'b0);
    expect_at(3, "os_dec1",   1, 1'b1, 1'b0, 1'b0);
    expect_at(4, "os_dec0",   0, 1'b1, 1'b0, 1'b0);
    expect_at(5, "os_expire", 0, 1'b0, 1'b1, 1'b1);
    expect_at(6, "os_done",   0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    run(5);
    bus.clr_i = 1'b1;
    expect_at(1, "clr_done", 0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.clr_i = 1'b0;

    // load+start together, presc 2, auto-reload: period 9
    bus.load_i = 1'b1; bus.cnt_i = 8'd2; bus.start_i = 1'b1;
    bus.presc_i = 4'd2; bus.reload_en_i = 1'b1;
    expect_at(1,  "ar_start", 2, 1'b1, 1'b0, 1'b0);
    expect_at(4,  "ar_dec1",  1, 1'b1, 1'b0, 1'b0);
    expect_at(7,  "ar_dec0",  0, 1'b1, 1'b0, 1'b0);
    expect_at(10, "ar_exp1",  2, 1'b1, 1'b0, 1'b1);
    expect_at(11, "ar_pulse", 2, 1'b1, 1'b0, 1'b0);
    expect_at(13, "ar_dec1b", 1, 1'b1, 1'b0, 1'b0);
    expect_at(19, "ar_exp2",  2, 1'b1, 1'b0, 1'b1);
    expect_at(20, "ar_after", 2, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load_i = 1'b0; bus.start_i = 1'b0;
    run(19);

    // load in RUN only changes the reload value
    bus.load_i = 1'b1; bus.cnt_i = 8'd7;
    expect_at(1, "ldrun_hold", 2, 1'b1, 1'b0, 1'b0);
    expect_at(2, "ldrun_dec1", 1, 1'b1, 1'b0, 1'b0);
    expect_at(5, "ldrun_dec0", 0, 1'b1, 1'b0, 1'b0);
    expect_at(8, "ldrun_rl7",  7, 1'b1, 1'b0, 1'b1);
    tick();
    bus.load_i = 1'b0;
    run(7);

    // stop holds the count; restart resumes from it
    bus.presc_i = 4'd0;
    expect_at(1, "fast6", 6, 1'b1, 1'b0, 1'b0);
    expect_at(2, "fast5", 5, 1'b1, 1'b0, 1'b0);
    run(2);
    bus.stop_i = 1'b1;
    expect_at(1, "stop_hold", 5, 1'b0, 1'b0, 1'b0);
    expect_at(3, "idle_hold", 5, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stop_i = 1'b0;
    run(2);
    bus.start_i = 1'b1;
    expect_at(1, "resume",      5, 1'b1, 1'b0, 1'b0);
    expect_at(2, "resume_dec",  4, 1'b1, 1'b0, 1'b0);
    expect_at(6, "resume_zero", 0, 1'b1, 1'b0, 1'b0);
    expect_at(7, "stop_on_exp", 0, 1'b0, 1'b0, 1'b0);
    expect_at(8, "no_pulse",    0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start_i = 1'b0;
    run(5);
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    tick();

    // start from zero expires after P+1 cycles
    bus.presc_i = 4'd3; bus.reload_en_i = 1'b0; bus.start_i = 1'b1;
    expect_at(1, "z_start",  0, 1'b1, 1'b0, 1'b0);
    expect_at(4, "z_wait",   0, 1'b1, 1'b0, 1'b0);
    expect_at(5, "z_expire", 0, 1'b0, 1'b1, 1'b1);
    expect_at(6, "z_done",   0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.start_i = 1'b0;
    run(5);
    bus.clr_i = 1'b1;
    expect_at(1, "clr2", 0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.clr_i = 1'b0;

    // reset mid-prescale overrides everything; clr ignored in RUN
    bus.load_i = 1'b1; bus.cnt_i = 8'd9; bus.start_i = 1'b1;
    expect_at(1, "r_start", 9, 1'b1, 1'b0, 1'b0);
    expect_at(5, "r_dec",   8, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load_i = 1'b0; bus.start_i = 1'b0; bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
    run(4);
    rst = 1'b1; bus.start_i = 1'b1; bus.load_i = 1'b1; bus.cnt_i = 8'd5;
    expect_at(1, "rst_run", 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; bus.load_i = 1'b0; bus.start_i = 1'b0;
    expect_at(1, "rst_idle", 0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start_i = 1'b1;
    expect_at(1, "rst_start",  0, 1'b1, 1'b0, 1'b0);
    expect_at(5, "rst_expire", 0, 1'b0, 1'b1, 1'b1);
    tick();
    bus.start_i = 1'b0;
    run(4);
    bus.clr_i = 1'b1;
    expect_at(1, "clr3", 0, 1'b0, 1'b0, 1'b0);
    tick();
    bus.clr_i = 1'b0;

    // lowering presc mid-run ticks on the next cycle
    bus.load_i = 1'b1; bus.cnt_i = 8'd4; bus.start_i = 1'b1; bus.presc_i = 4'd9;
    expect_at(1, "lp_start", 4, 1'b1, 1'b0, 1'b0);
    expect_at(3, "lp_hold",  4, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load_i = 1'b0; bus.start_i = 1'b0;
    run(2);
    bus.presc_i = 4'd1;
    expect_at(1, "lp_tick", 3, 1'b1, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    checks++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL drain: observed %0d pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
